ex: RTL and testbench

EX -- requirements
Module: ex

---
 rtl/ex.sv | 239 +++++++++++++++++++++++
 tb/tb_ex.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ex.sv
`timescale 1ns/1ps
// Execute stage: logic/shift/arith/move/HI-LO ops plus single-cycle multiply and a restoring divider.
// Latency: combinational for everything except DIV/DIVU (34 cycles, 3 on divide-by-zero).
// Backpressure: raises stallreq_o while a divide is busy; upstream holds the operands until the result cycle.
// Ports: clk/rst; aluop_i/alusel_i, reg1_i/reg2_i, wd_i/wreg_i from ID/EX; hi_i/lo_i plus MEM/WB HI-LO
//        forwarding; flush_i; GPR write (wd_o/wreg_o/wdata_o), HI-LO write (whilo_o/hi_o/lo_o), stallreq_o.
module ex (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        mem_whilo_i,
    input  logic [31:0] mem_hi_i,
    input  logic [31:0] mem_lo_i,
    input  logic        wb_whilo_i,
    input  logic [31:0] wb_hi_i,
    input  logic [31:0] wb_lo_i,
    input  logic        flush_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);
    localparam logic [7:0] OP_AND  = 8'b0010_0100, OP_OR   = 8'b0010_0101;
    localparam logic [7:0] OP_XOR  = 8'b0010_0110, OP_NOR  = 8'b0010_0111;
    localparam logic [7:0] OP_SLL  = 8'b0111_1100, OP_SRL  = 8'b0000_0010, OP_SRA = 8'b0000_0011;
    localparam logic [7:0] OP_MOVZ = 8'b0000_1010, OP_MOVN = 8'b0000_1011;
    localparam logic [7:0] OP_MFHI = 8'b0001_0000, OP_MTHI = 8'b0001_0001;
    localparam logic [7:0] OP_MFLO = 8'b0001_0010, OP_MTLO = 8'b0001_0011;
    localparam logic [7:0] OP_SLT  = 8'b0010_1010, OP_SLTU = 8'b0010_1011;
    localparam logic [7:0] OP_ADD  = 8'b0010_0000, OP_ADDU = 8'b0010_0001;
    localparam logic [7:0] OP_SUB  = 8'b0010_0010, OP_SUBU = 8'b0010_0011, OP_ADDI = 8'b0101_0101;
    localparam logic [7:0] OP_MULT = 8'b0001_1000, OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] OP_DIV  = 8'b0001_1010, OP_DIVU = 8'b0001_1011;

    localparam logic [2:0] SEL_NOP   = 3'b000, SEL_LOGIC = 3'b001, SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_MOVE  = 3'b011, SEL_ARITH = 3'b100;

    typedef enum logic [1:0] {DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END} div_state_t;

    div_state_t  state_q, state_d;
    logic [5:0]  cnt_q;
    logic [31:0] quo_q, rem_q, dsr_q;
    logic        neg_quo_q, neg_rem_q;

    // HI/LO as this instruction must see them: youngest in-flight write wins.
    logic [31:0] hi_res, lo_res;
    always_comb begin
        hi_res = hi_i;
        lo_res = lo_i;
        if (mem_whilo_i) begin
            hi_res = mem_hi_i;
            lo_res = mem_lo_i;
        end else if (wb_whilo_i) begin
            hi_res = wb_hi_i;
            lo_res = wb_lo_i;
        end
    end

    logic [31:0] sum, diff;
    logic        ov_add, ov_sub;
    assign sum    = reg1_i + reg2_i;
    assign diff   = reg1_i - reg2_i;
    assign ov_add = (reg1_i[31] == reg2_i[31]) && (sum[31] != reg1_i[31]);
    assign ov_sub = (reg1_i[31] != reg2_i[31]) && (diff[31] != reg1_i[31]);

    // Extending to 64 bits first makes the low 64 bits of the product correct for both signednesses.
    logic        mul_signed;
    logic [63:0] mul_a, mul_b, prod;
    assign mul_signed = (aluop_i == OP_MULT);
    assign mul_a = mul_signed ? {{32{reg1_i[31]}}, reg1_i} : {32'd0, reg1_i};
    assign mul_b = mul_signed ? {{32{reg2_i[31]}}, reg2_i} : {32'd0, reg2_i};
    assign prod  = mul_a * mul_b;

    logic        is_div, div_signed;
    logic [31:0] dvd_mag, dsr_mag;
    assign is_div     = (alusel_i == SEL_NOP) && ((aluop_i == OP_DIV) || (aluop_i == OP_DIVU));
    assign div_signed = (aluop_i == OP_DIV);
    assign dvd_mag    = (div_signed && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
    assign dsr_mag    = (div_signed && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;

    // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
    // The shifted remainder is always below 2*divisor, so the difference fits in 32 bits.
    logic [32:0] sh;
    logic        div_ge;
    logic [31:0] rem_step, quo_step;
    always_comb begin
        sh       = {rem_q, quo_q[31]};
        div_ge   = (sh >= {1'b0, dsr_q});
        rem_step = div_ge ? (sh[31:0] - dsr_q) : sh[31:0];
        quo_step = {quo_q[30:0], div_ge};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_FREE:   if (is_div) state_d = (reg2_i == 32'd0) ? DIV_BYZERO : DIV_ON;
            DIV_BYZERO: state_d = DIV_END;
            DIV_ON:     if (cnt_q == 6'd31) state_d = DIV_END;
            DIV_END:    state_d = DIV_FREE;
            default:    state_d = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            state_q   <= DIV_FREE;
            cnt_q     <= 6'd0;
            quo_q     <= 32'd0;
            rem_q     <= 32'd0;
            dsr_q     <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                DIV_FREE: begin
                    cnt_q <= 6'd0;
                    if (is_div) begin
                        // Divide-by-zero leaves a zero quotient and remainder.
                        quo_q     <= (reg2_i == 32'd0) ? 32'd0 : dvd_mag;
                        rem_q     <= 32'd0;
                        dsr_q     <= dsr_mag;
                        neg_quo_q <= (reg2_i != 32'd0) && div_signed && (reg1_i[31] ^ reg2_i[31]);
                        neg_rem_q <= (reg2_i != 32'd0) && div_signed && reg1_i[31];
                    end
                end
                DIV_ON: begin
                    quo_q <= quo_step;
                    rem_q <= rem_step;
                    cnt_q <= cnt_q + 6'd1;
                end
                default: cnt_q <= 6'd0;
            endcase
        end
    end

    logic [31:0] quo_out, rem_out;
    assign quo_out = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
    assign rem_out = neg_rem_q ? (~rem_q + 32'd1) : rem_q;

    logic valid;
    always_comb begin
        valid      = 1'b0;
        wd_o       = 5'd0;
        wreg_o     = 1'b0;
        wdata_o    = 32'd0;
        whilo_o    = 1'b0;
        hi_o       = 32'd0;
        lo_o       = 32'd0;
        stallreq_o = 1'b0;
        if (!rst) begin
            wd_o   = wd_i;
            wreg_o = wreg_i;
            case (aluop_i)
                OP_OR, OP_AND, OP_XOR, OP_NOR: if (alusel_i == SEL_LOGIC) begin
                    valid = 1'b1;
                    case (aluop_i)
                        OP_OR:   wdata_o = reg1_i | reg2_i;
                        OP_AND:  wdata_o = reg1_i & reg2_i;
                        OP_XOR:  wdata_o = reg1_i ^ reg2_i;
                        default: wdata_o = ~(reg1_i | reg2_i);
                    endcase
                end
                OP_SLL, OP_SRL, OP_SRA: if (alusel_i == SEL_SHIFT) begin
                    valid = 1'b1;
                    case (aluop_i)
                        OP_SLL:  wdata_o = reg2_i << reg1_i[4:0];
                        OP_SRL:  wdata_o = reg2_i >> reg1_i[4:0];
                        default: wdata_o = $signed(reg2_i) >>> reg1_i[4:0];
                    endcase
                end
                OP_ADD, OP_ADDI, OP_ADDU, OP_SUB, OP_SUBU, OP_SLT, OP_SLTU: if (alusel_i == SEL_ARITH) begin
                    valid = 1'b1;
                    case (aluop_i)
                        OP_ADD, OP_ADDI: begin
                            wdata_o = sum;
                            if (ov_add) wreg_o = 1'b0;
                        end
                        OP_ADDU: wdata_o = sum;
                        OP_SUB: begin
                            wdata_o = diff;
                            if (ov_sub) wreg_o = 1'b0;
                        end
                        OP_SUBU: wdata_o = diff;
                        OP_SLT:  wdata_o = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
                        default: wdata_o = {31'd0, reg1_i < reg2_i};
                    endcase
                end
                OP_MFHI, OP_MFLO, OP_MOVZ, OP_MOVN: if (alusel_i == SEL_MOVE) begin
                    valid = 1'b1;
                    case (aluop_i)
                        OP_MFHI: wdata_o = hi_res;
                        OP_MFLO: wdata_o = lo_res;
                        default: wdata_o = reg1_i;
                    endcase
                end
                OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU: if (alusel_i == SEL_NOP) begin
                    valid   = 1'b1;
                    whilo_o = 1'b1;
                    case (aluop_i)
                        OP_MTHI: begin hi_o = reg1_i; lo_o = lo_res; end
                        OP_MTLO: begin hi_o = hi_res; lo_o = reg1_i; end
                        default: begin hi_o = prod[63:32]; lo_o = prod[31:0]; end
                    endcase
                end
                OP_DIV, OP_DIVU: if (alusel_i == SEL_NOP) begin
                    valid = 1'b1;
                    if (state_q == DIV_END) begin
                        whilo_o = 1'b1;
                        hi_o    = rem_out;
                        lo_o    = quo_out;
                    end else begin
                        stallreq_o = 1'b1;
                    end
                end
                default: valid = 1'b0;
            endcase
            if (!valid) begin
                wd_o   = 5'd0;
                wreg_o = 1'b0;
            end
            if (flush_i) begin
                wreg_o     = 1'b0;
                whilo_o    = 1'b0;
                stallreq_o = 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ex.sv
`timescale 1ns/1ps
module tb_ex;
    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_AND  = 8'b0010_0100, OP_OR   = 8'b0010_0101;
    localparam logic [7:0] OP_XOR  = 8'b0010_0110, OP_NOR  = 8'b0010_0111;
    localparam logic [7:0] OP_SLL  = 8'b0111_1100, OP_SRL  = 8'b0000_0010, OP_SRA = 8'b0000_0011;
    localparam logic [7:0] OP_MOVN = 8'b0000_1011;
    localparam logic [7:0] OP_MFHI = 8'b0001_0000, OP_MTHI = 8'b0001_0001;
    localparam logic [7:0] OP_MFLO = 8'b0001_0010, OP_MTLO = 8'b0001_0011;
    localparam logic [7:0] OP_SLT  = 8'b0010_1010, OP_SLTU = 8'b0010_1011;
    localparam logic [7:0] OP_ADD  = 8'b0010_0000, OP_ADDU = 8'b0010_0001;
    localparam logic [7:0] OP_SUB  = 8'b0010_0010, OP_SUBU = 8'b0010_0011, OP_ADDI = 8'b0101_0101;
    localparam logic [7:0] OP_MULT = 8'b0001_1000, OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] OP_DIV  = 8'b0001_1010, OP_DIVU = 8'b0001_1011;
    localparam logic [2:0] SEL_NOP = 3'b000, SEL_LOGIC = 3'b001, SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_MOVE = 3'b011, SEL_ARITH = 3'b100;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] hi_i, lo_i;
    logic        mem_whilo_i, wb_whilo_i;
    logic [31:0] mem_hi_i, mem_lo_i, wb_hi_i, wb_lo_i;
    logic        flush_i;
    logic [4:0]  wd_o;
    logic        wreg_o, whilo_o, stallreq_o;
    logic [31:0] wdata_o, hi_o, lo_o;

    ex dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .hi_i(hi_i), .lo_i(lo_i),
        .mem_whilo_i(mem_whilo_i), .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i),
        .wb_whilo_i(wb_whilo_i), .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i),
        .flush_i(flush_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_wd"},    {27'd0, wd_o}, 32'd0);
        chk({nm, "_wreg"},  {31'd0, wreg_o}, 32'd0);
        chk({nm, "_wdata"}, wdata_o, 32'd0);
        chk({nm, "_whilo"}, {31'd0, whilo_o}, 32'd0);
        chk({nm, "_hi"},    hi_o, 32'd0);
        chk({nm, "_lo"},    lo_o, 32'd0);
        chk({nm, "_stall"}, {31'd0, stallreq_o}, 32'd0);
    endtask

    // Presents a divide and expects stall (with no HI/LO write) in cycles 0..lat-1, result in cycle lat.
    // With hold set, the divide is left on the inputs after the result cycle.
    task automatic run_div(input string nm, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int lat, input logic [31:0] q, input logic [31:0] r, input bit hold);
        aluop_i = op; alusel_i = SEL_NOP; reg1_i = a; reg2_i = b; wreg_i = 1'b0;
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            chk($sformatf("%s_c%0d_stall_whilo", nm, c), {30'd0, stallreq_o, whilo_o}, 32'd2);
            next_cycle();
        end
        @(negedge clk);
        chk({nm, "_res_whilo"}, {31'd0, whilo_o}, 32'd1);
        chk({nm, "_res_lo"}, lo_o, q);
        chk({nm, "_res_hi"}, hi_o, r);
        chk({nm, "_res_stall"}, {31'd0, stallreq_o}, 32'd0);
        next_cycle();
        if (!hold) begin
            aluop_i = OP_NOP; alusel_i = SEL_NOP;
        end
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] r1, r2;
        logic        wr;
        logic [4:0]  e_wd;
        logic        e_wreg;
        logic [31:0] e_wdata;
        logic        e_whilo;
        logic [31:0] e_hi, e_lo;
    } vec_t;

    vec_t vecs [0:24];

    initial begin
        vecs[0]  = '{OP_OR,   SEL_LOGIC, 32'hFF00FF00, 32'h0FF00FF0, 1'b1, 5'd7, 1'b1, 32'hFFF0FFF0, 1'b0, 32'h0, 32'h0};
        vecs[1]  = '{OP_AND,  SEL_LOGIC, 32'hFF00FF00, 32'h0FF00FF0, 1'b1, 5'd7, 1'b1, 32'h0F000F00, 1'b0, 32'h0, 32'h0};
        vecs[2]  = '{OP_XOR,  SEL_LOGIC, 32'hFF00FF00, 32'h0FF00FF0, 1'b1, 5'd7, 1'b1, 32'hF0F0F0F0, 1'b0, 32'h0, 32'h0};
        vecs[3]  = '{OP_NOR,  SEL_LOGIC, 32'hFF00FF00, 32'h0FF00FF0, 1'b1, 5'd7, 1'b1, 32'h000F000F, 1'b0, 32'h0, 32'h0};
        vecs[4]  = '{OP_SLL,  SEL_SHIFT, 32'h00000004, 32'h8000000F, 1'b1, 5'd7, 1'b1, 32'h000000F0, 1'b0, 32'h0, 32'h0};
        vecs[5]  = '{OP_SRL,  SEL_SHIFT, 32'h00000004, 32'h8000000F, 1'b1, 5'd7, 1'b1, 32'h08000000, 1'b0, 32'h0, 32'h0};
        vecs[6]  = '{OP_SRA,  SEL_SHIFT, 32'h00000004, 32'h8000000F, 1'b1, 5'd7, 1'b1, 32'hF8000000, 1'b0, 32'h0, 32'h0};
        vecs[7]  = '{OP_ADD,  SEL_ARITH, 32'h7FFFFFFF, 32'h00000001, 1'b1, 5'd7, 1'b0, 32'h80000000, 1'b0, 32'h0, 32'h0};
        vecs[8]  = '{OP_ADDU, SEL_ARITH, 32'h7FFFFFFF, 32'h00000001, 1'b1, 5'd7, 1'b1, 32'h80000000, 1'b0, 32'h0, 32'h0};
        vecs[9]  = '{OP_SUB,  SEL_ARITH, 32'h80000000, 32'h00000001, 1'b1, 5'd7, 1'b0, 32'h7FFFFFFF, 1'b0, 32'h0, 32'h0};
        vecs[10] = '{OP_SUBU, SEL_ARITH, 32'h00000005, 32'h00000007, 1'b1, 5'd7, 1'b1, 32'hFFFFFFFE, 1'b0, 32'h0, 32'h0};
        vecs[11] = '{OP_SLT,  SEL_ARITH, 32'hFFFFFFFF, 32'h00000001, 1'b1, 5'd7, 1'b1, 32'h00000001, 1'b0, 32'h0, 32'h0};
        vecs[12] = '{OP_SLTU, SEL_ARITH, 32'hFFFFFFFF, 32'h00000001, 1'b1, 5'd7, 1'b1, 32'h00000000, 1'b0, 32'h0, 32'h0};
        vecs[13] = '{OP_ADDI, SEL_ARITH, 32'h00000001, 32'h00000002, 1'b1, 5'd7, 1'b1, 32'h00000003, 1'b0, 32'h0, 32'h0};
        vecs[14] = '{OP_MFHI, SEL_MOVE,  32'h0,        32'h0,        1'b1, 5'd7, 1'b1, 32'hAAAA0000, 1'b0, 32'h0, 32'h0};
        vecs[15] = '{OP_MFLO, SEL_MOVE,  32'h0,        32'h0,        1'b1, 5'd7, 1'b1, 32'h0000BBBB, 1'b0, 32'h0, 32'h0};
        vecs[16] = '{OP_MOVN, SEL_MOVE,  32'h12345678, 32'h00000001, 1'b1, 5'd7, 1'b1, 32'h12345678, 1'b0, 32'h0, 32'h0};
        vecs[17] = '{OP_MTHI, SEL_NOP,   32'hDEADBEEF, 32'h0,        1'b0, 5'd7, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 32'h0000BBBB};
        vecs[18] = '{OP_MTLO, SEL_NOP,   32'hCAFEF00D, 32'h0,        1'b0, 5'd7, 1'b0, 32'h0, 1'b1, 32'hAAAA0000, 32'hCAFEF00D};
        vecs[19] = '{OP_MULT, SEL_NOP,   32'hFFFFFFFF, 32'h00000002, 1'b0, 5'd7, 1'b0, 32'h0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[20] = '{OP_MULTU, SEL_NOP,  32'hFFFFFFFF, 32'h00000002, 1'b0, 5'd7, 1'b0, 32'h0, 1'b1, 32'h00000001, 32'hFFFFFFFE};
        vecs[21] = '{OP_NOP,  SEL_NOP,   32'h00000005, 32'h00000006, 1'b1, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
        vecs[22] = '{8'hFF,   SEL_LOGIC, 32'h00000005, 32'h00000006, 1'b1, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
        vecs[23] = '{OP_ADD,  SEL_LOGIC, 32'h00000005, 32'h00000006, 1'b1, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
        vecs[24] = '{OP_ADD,  SEL_ARITH, 32'h00000005, 32'hFFFFFFFD, 1'b1, 5'd7, 1'b1, 32'h00000002, 1'b0, 32'h0, 32'h0};

        rst = 1'b1; flush_i = 1'b0;
        aluop_i = OP_ADDU; alusel_i = SEL_ARITH; reg1_i = 32'h1; reg2_i = 32'h2;
        wd_i = 5'd7; wreg_i = 1'b1;
        hi_i = 32'hAAAA0000; lo_i = 32'h0000BBBB;
        mem_whilo_i = 1'b0; mem_hi_i = 32'h0; mem_lo_i = 32'h0;
        wb_whilo_i = 1'b0; wb_hi_i = 32'h0; wb_lo_i = 32'h0;

        // Reset holds every output at zero even with a live instruction presented.
        next_cycle();
        @(negedge clk);
        chk_all_zero("reset");
        next_cycle();
        rst = 1'b0;

        foreach (vecs[i]) begin
            aluop_i = vecs[i].op; alusel_i = vecs[i].sel;
            reg1_i = vecs[i].r1; reg2_i = vecs[i].r2; wreg_i = vecs[i].wr;
            @(negedge clk);
            chk($sformatf("v%0d_wd", i),    {27'd0, wd_o}, {27'd0, vecs[i].e_wd});
            chk($sformatf("v%0d_wreg", i),  {31'd0, wreg_o}, {31'd0, vecs[i].e_wreg});
            chk($sformatf("v%0d_wdata", i), wdata_o, vecs[i].e_wdata);
            chk($sformatf("v%0d_whilo", i), {31'd0, whilo_o}, {31'd0, vecs[i].e_whilo});
            chk($sformatf("v%0d_hi", i),    hi_o, vecs[i].e_hi);
            chk($sformatf("v%0d_lo", i),    lo_o, vecs[i].e_lo);
            chk($sformatf("v%0d_stall", i), {31'd0, stallreq_o}, 32'd0);
            next_cycle();
        end

        // HI/LO forwarding priority: MEM over WB over architectural.
        aluop_i = OP_MFHI; alusel_i = SEL_MOVE; wreg_i = 1'b1;
        hi_i = 32'h1111; wb_hi_i = 32'h2222; wb_whilo_i = 1'b1; mem_hi_i = 32'h3333; mem_whilo_i = 1'b1;
        lo_i = 32'h5; wb_lo_i = 32'h6; mem_lo_i = 32'h7;
        @(negedge clk); chk("fwd_mfhi_mem", wdata_o, 32'h3333); next_cycle();
        mem_whilo_i = 1'b0;
        @(negedge clk); chk("fwd_mfhi_wb", wdata_o, 32'h2222); next_cycle();
        wb_whilo_i = 1'b0;
        @(negedge clk); chk("fwd_mfhi_arch", wdata_o, 32'h1111); next_cycle();
        aluop_i = OP_MFLO; wb_whilo_i = 1'b1; mem_whilo_i = 1'b1;
        @(negedge clk); chk("fwd_mflo_mem", wdata_o, 32'h7); next_cycle();
        aluop_i = OP_MTHI; alusel_i = SEL_NOP; reg1_i = 32'h99; wreg_i = 1'b0; mem_whilo_i = 1'b0;
        @(negedge clk); chk("fwd_mthi_lo", lo_o, 32'h6); chk("fwd_mthi_hi", hi_o, 32'h99); next_cycle();
        wb_whilo_i = 1'b0; hi_i = 32'hAAAA0000; lo_i = 32'h0000BBBB;

        // Divides: signed -7/2, unsigned, signed with negative divisor, divide-by-zero.
        run_div("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'h2, 33, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        run_div("divu_big", OP_DIVU, 32'hFFFFFFFF, 32'h10, 33, 32'h0FFFFFFF, 32'hF, 1'b0);
        run_div("div_7_m2", OP_DIV, 32'h7, 32'hFFFFFFFE, 33, 32'hFFFFFFFD, 32'h1, 1'b0);
        run_div("divu_by0", OP_DIVU, 32'd10, 32'd0, 2, 32'h0, 32'h0, 1'b0);

        // A divide still presented after its result cycle starts over.
        run_div("div_b2b", OP_DIV, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b1);
        @(negedge clk);
        chk("b2b_restart_stall_whilo", {30'd0, stallreq_o, whilo_o}, 32'd2);
        next_cycle();
        run_div("div_b2b_2", OP_DIV, 32'd100, 32'd7, 32, 32'd14, 32'd2, 1'b0);

        // Flush in cycle 10 of a divide: outputs squashed, next divide takes the full latency.
        aluop_i = OP_DIV; alusel_i = SEL_NOP; reg1_i = 32'hFFFFFFF9; reg2_i = 32'h2;
        for (int c = 0; c < 10; c++) next_cycle();
        flush_i = 1'b1; wreg_i = 1'b1;
        @(negedge clk);
        chk("flush_wreg", {31'd0, wreg_o}, 32'd0);
        chk("flush_whilo", {31'd0, whilo_o}, 32'd0);
        chk("flush_stall", {31'd0, stallreq_o}, 32'd0);
        next_cycle();
        flush_i = 1'b0;
        run_div("div_after_flush", OP_DIV, 32'hFFFFFFF9, 32'h2, 33, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);

        // Reset in cycle 10 of a divide: everything zero, division abandoned.
        aluop_i = OP_DIV; alusel_i = SEL_NOP; reg1_i = 32'hFFFFFFF9; reg2_i = 32'h2;
        for (int c = 0; c < 10; c++) next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("rst_mid_div");
        next_cycle();
        rst = 1'b0;
        run_div("div_after_rst", OP_DIVU, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
